alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
// Initiator side of the ALU interface. Accepts decoded MIPS instruction fields and register operands and
// decodes them into the 5-bit ALU op and the a/b operands. The ALU is combinational; this block drives it
// from a stage-1 register, captures r/intov into a stage-2 register and emits the result with a write-back
// decision. It sits between register read and write-back and owns the arithmetic-overflow trap.
// PARAMETERS
// TRAP_EN    1  1: ADD/SUB/ADDI signed overflow suppresses write and raises out_ovf_exc; 0: never trap
// ZERO_SUPP  1  1: dest==0 forces out_wen=0
// PORTS
// clk           in   1   clock, rising edge
// reset         in   1   asynchronous, active-high reset
// in_valid      in   1   input beat valid
// in_ready      out  1   block accepts beat this cycle
// in_op         in   6   instr[31:26]
// in_funct      in   6   instr[5:0]
// in_shamt      in   5   instr[10:6]
// in_imm        in   16  instr[15:0]
// in_rs_val     in   32  rs register value
// in_rt_val     in   32  rt register value
// in_dest       in   5   destination register (rd for R-type, rt for I-type; chosen upstream)
// alu_a         out  32  ALU operand a (shift amount for shifts)
// alu_b         out  32  ALU operand b (shifted value for shifts)
// alu_control   out  5   ALU op
// alu_r         in   32  ALU result
// alu_intov     in   1   ALU bit 32 (carry/shift-out); passed through as out_carry only
// out_valid     out  1   result beat valid
// out_ready     in   1   downstream accepts result
// out_result    out  32  result
// out_dest      out  5   destination register
// out_wen       out  1   write-back enable
// out_ovf_exc   out  1   signed-overflow exception
// out_illegal   out  1   unsupported op/funct
// out_carry     out  1   captured alu_intov
// BEHAVIOUR
// - Reset: s1_valid=s2_valid=0; all stage registers 0, so alu_a=alu_b=0, alu_control=00000, all out_* = 0.
//   Reset mid-operation discards both stages; no beat survives.
// - Pipeline: s1_adv = !s2_valid | out_ready; in_ready = !s1_valid | s1_adv. Accept when in_valid&in_ready.
//   Accept at edge N -> out_valid at edge N+1 -> latency 2 cycles. Full throughput 1 beat/cycle with out_ready=1.
// - out_ready=0 with s2_valid: stage 2 holds and all out_* stable; stage 1 holds; in_ready=!s1_valid.
//   Accept and drain in the same cycle are both performed (no bubble). in_valid=0: stage-1 valid clears on advance.
// - ALU op: AND 00000, OR 01000, NOR 10000, XOR 11000, ADD 00001, SUB 01001, SLT 01010, SRL 00100, SRA 01100, SLL 10100.
// - Decode (op=0): funct 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 00 SLL/02 SRL/03 SRA
//   (a={27'b0,shamt}, b=rt), 04 SLLV/06 SRLV/07 SRAV (a={27'b0,rs[4:0]}, b=rt); else a=rs, b=rt.
// - Decode (I-type, a=rs): 08 ADDI, 09 ADDIU, 0A SLTI use b=sext(imm); 0C ANDI, 0D ORI, 0E XORI use b=zext(imm);
//   0F LUI: SLL with a=16, b=zext(imm).
// - Trapping ops: ADD (funct 20), SUB (22), ADDI (08) only. Overflow, computed at stage-2 capture from stage-1
//   operands and alu_r: ADD: a[31]==b[31] & r[31]!=a[31]; SUB: a[31]!=b[31] & r[31]!=a[31].
// - out_wen = !illegal & !(TRAP_EN & ovf) & !(ZERO_SUPP & dest==0). out_ovf_exc = TRAP_EN & ovf.
// - Unsupported op/funct: alu_control=00000, a=b=0, out_illegal=1, out_result=0, out_wen=0, out_ovf_exc=0.
// - out_result = alu_r as captured; out_carry = alu_intov; never used for trap decisions.
// TESTING
// 1 Reset asserted while a beat is in each stage -> out_valid=0, in_ready=1, alu_control=00000 one edge later.
// 2 ADD rs=7FFFFFFF rt=1 dest=3 -> out_result=80000000, out_ovf_exc=1, out_wen=0; ADDU same -> ovf=0, wen=1.
// 3 ADDI rs=5 imm=FFFF -> b=FFFFFFFF, out_result=4, out_wen=1; ORI rs=0 imm=FFFF -> b=0000FFFF, result 0000FFFF.
// 4 LUI imm=1234 dest=8 -> alu_control=10100, a=16, out_result=12340000; SRAV rs=24 rt=80000000 -> a=4.
// 5 Back-to-back 4 beats, out_ready low 3 cycles mid-stream -> in order, no loss/dup, out_* stable while stalled.
// 6 op=3F -> out_illegal=1, out_wen=0; ADD dest=0 -> out_wen=0, out_result still valid.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Initiator side of a combinational ALU. Decodes MIPS R/I-type fields into
// an ALU op and operands held in a stage-1 register, then captures the ALU
// result into a stage-2 register along with a write-back decision and the
// signed-overflow trap.
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   in_valid/in_ready     input handshake
//   in_op/funct/shamt/imm decoded instruction fields
//   in_rs_val, in_rt_val  register operands
//   in_dest               destination register
//   alu_a/b/control       drive to the ALU (from stage 1)
//   alu_r, alu_intov      ALU result and bit 32
//   out_valid/out_ready   output handshake
//   out_result/dest/wen/ovf_exc/illegal/carry   stage-2 result beat
module alu_issue_ctrl #(
    parameter bit TRAP_EN   = 1'b1,
    parameter bit ZERO_SUPP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic [4:0]  in_dest,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_control,
    input  logic [31:0] alu_r,
    input  logic        alu_intov,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_dest,
    output logic        out_wen,
    output logic        out_ovf_exc,
    output logic        out_illegal,
    output logic        out_carry
);

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b01000;
    localparam logic [4:0] OP_NOR = 5'b10000;
    localparam logic [4:0] OP_XOR = 5'b11000;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b01001;
    localparam logic [4:0] OP_SLT = 5'b01010;
    localparam logic [4:0] OP_SRL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b01100;
    localparam logic [4:0] OP_SLL = 5'b10100;

    logic        s1_valid;
    logic        s2_valid;
    logic        s1_adv;
    logic        accept;
    logic [4:0]  s1_dest;
    logic        s1_illegal;
    logic        s1_chk_add;
    logic        s1_chk_sub;

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_ctrl;
    logic        dec_illegal;
    logic        dec_chk_add;
    logic        dec_chk_sub;

    logic        ovf;
    logic        trap;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    assign imm_sext = {{16{in_imm[15]}}, in_imm};
    assign imm_zext = {16'h0000, in_imm};

    always_comb begin
        dec_a       = in_rs_val;
        dec_b       = in_rt_val;
        dec_ctrl    = OP_AND;
        dec_illegal = 1'b0;
        dec_chk_add = 1'b0;
        dec_chk_sub = 1'b0;
        if (in_op == 6'h00) begin
            case (in_funct)
                6'h20: begin dec_ctrl = OP_ADD; dec_chk_add = 1'b1; end
                6'h21: dec_ctrl = OP_ADD;
                6'h22: begin dec_ctrl = OP_SUB; dec_chk_sub = 1'b1; end
                6'h23: dec_ctrl = OP_SUB;
                6'h24: dec_ctrl = OP_AND;
                6'h25: dec_ctrl = OP_OR;
                6'h26: dec_ctrl = OP_XOR;
                6'h27: dec_ctrl = OP_NOR;
                6'h2A: dec_ctrl = OP_SLT;
                6'h00: begin dec_ctrl = OP_SLL; dec_a = {27'd0, in_shamt}; end
                6'h02: begin dec_ctrl = OP_SRL; dec_a = {27'd0, in_shamt}; end
                6'h03: begin dec_ctrl = OP_SRA; dec_a = {27'd0, in_shamt}; end
                6'h04: begin dec_ctrl = OP_SLL; dec_a = {27'd0, in_rs_val[4:0]}; end
                6'h06: begin dec_ctrl = OP_SRL; dec_a = {27'd0, in_rs_val[4:0]}; end
                6'h07: begin dec_ctrl = OP_SRA; dec_a = {27'd0, in_rs_val[4:0]}; end
                default: begin
                    dec_illegal = 1'b1;
                    dec_a       = '0;
                    dec_b       = '0;
                end
            endcase
        end else begin
            case (in_op)
                6'h08: begin dec_ctrl = OP_ADD; dec_b = imm_sext; dec_chk_add = 1'b1; end
                6'h09: begin dec_ctrl = OP_ADD; dec_b = imm_sext; end
                6'h0A: begin dec_ctrl = OP_SLT; dec_b = imm_sext; end
                6'h0C: begin dec_ctrl = OP_AND; dec_b = imm_zext; end
                6'h0D: begin dec_ctrl = OP_OR;  dec_b = imm_zext; end
                6'h0E: begin dec_ctrl = OP_XOR; dec_b = imm_zext; end
                // LUI is a shift of the zero-extended immediate by 16
                6'h0F: begin dec_ctrl = OP_SLL; dec_a = 32'd16; dec_b = imm_zext; end
                default: begin
                    dec_illegal = 1'b1;
                    dec_a       = '0;
                    dec_b       = '0;
                end
            endcase
        end
    end

    // Signed overflow judged from the operands actually driven and the result
    assign ovf = (s1_chk_add && (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31])) ||
                 (s1_chk_sub && (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]));
    assign trap = TRAP_EN && ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= OP_AND;
            s1_dest     <= '0;
            s1_illegal  <= 1'b0;
            s1_chk_add  <= 1'b0;
            s1_chk_sub  <= 1'b0;
            out_result  <= '0;
            out_dest    <= '0;
            out_wen     <= 1'b0;
            out_ovf_exc <= 1'b0;
            out_illegal <= 1'b0;
            out_carry   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (accept) begin
                    alu_a       <= dec_a;
                    alu_b       <= dec_b;
                    alu_control <= dec_ctrl;
                    s1_dest     <= in_dest;
                    s1_illegal  <= dec_illegal;
                    s1_chk_add  <= dec_chk_add;
                    s1_chk_sub  <= dec_chk_sub;
                end
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_result  <= s1_illegal ? 32'd0 : alu_r;
                    out_carry   <= s1_illegal ? 1'b0 : alu_intov;
                    out_dest    <= s1_dest;
                    out_illegal <= s1_illegal;
                    out_ovf_exc <= trap && !s1_illegal;
                    out_wen     <= !s1_illegal && !trap && !(ZERO_SUPP && (s1_dest == 5'd0));
                end
            end
        end
    end

endmodule
